// File: rtl/specialist_pkg.sv
// Shared VRAM geometry and fill-engine state encoding.
// The video block uses the same geometry constants.
package specialist_pkg;

  localparam int unsigned VramCols = 48;
  localparam logic [15:0] VramBase = 16'h9000;

  typedef enum logic [1:0] {
    StIdle,
    StCheck,
    StWrite,
    StFinish
  } fill_state_e;

endpackage

// File: rtl/vram_fill.sv
// Rectangular VRAM fill engine.
// Writes one bitmap/attribute byte pair per granted bus slot, scanning rows within each column.
module vram_fill
  import specialist_pkg::*;
#(
  parameter int unsigned COLS = VramCols,
  parameter logic [15:0] BASE = VramBase
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  col0,
  input  logic [5:0]  col1,
  input  logic [7:0]  row0,
  input  logic [7:0]  row1,
  input  logic [7:0]  pattern,
  input  logic [7:0]  color_in,
  input  logic        grant,
  output logic [15:0] addr,
  output logic [7:0]  data,
  output logic [7:0]  color,
  output logic        we,
  output logic        busy,
  output logic        done,
  output logic        err
);

  fill_state_e state_q, state_d;
  logic [5:0]  col0_q, col0_d, col1_q, col1_d, cur_col_q, cur_col_d;
  logic [7:0]  row0_q, row0_d, row1_q, row1_d, cur_row_q, cur_row_d;
  logic [7:0]  pat_q, pat_d, clr_q, clr_d;
  logic        rej_q, rej_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d, color_q, color_d;
  logic        we_q, we_d, busy_q, busy_d, done_q, done_d, err_q, err_d;

  always_comb begin
    state_d   = state_q;
    col0_d    = col0_q;
    col1_d    = col1_q;
    row0_d    = row0_q;
    row1_d    = row1_q;
    pat_d     = pat_q;
    clr_d     = clr_q;
    cur_col_d = cur_col_q;
    cur_row_d = cur_row_q;
    rej_d     = rej_q;
    addr_d    = addr_q;
    data_d    = data_q;
    color_d   = color_q;
    we_d      = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = err_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          col0_d  = col0;
          col1_d  = col1;
          row0_d  = row0;
          row1_d  = row1;
          pat_d   = pattern;
          clr_d   = color_in;
          rej_d   = 1'b0;
          err_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = StCheck;
        end
      end
      StCheck: begin
        if ((col0_q > col1_q) || (row0_q > row1_q) || ({26'd0, col1_q} >= COLS)) begin
          rej_d   = 1'b1;
          state_d = StFinish;
        end else begin
          cur_col_d = col0_q;
          cur_row_d = row0_q;
          state_d   = StWrite;
        end
      end
      StWrite: begin
        if (grant) begin
          we_d    = 1'b1;
          addr_d  = BASE + {2'b00, cur_col_q, cur_row_q};
          data_d  = pat_q;
          color_d = clr_q;
          // Compare before incrementing so row1 = 255 never needs a 9-bit counter.
          if (cur_row_q == row1_q) begin
            cur_row_d = row0_q;
            if (cur_col_q == col1_q) begin
              state_d = StFinish;
            end else begin
              cur_col_d = cur_col_q + 6'd1;
            end
          end else begin
            cur_row_d = cur_row_q + 8'd1;
          end
        end
      end
      StFinish: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        err_d   = rej_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q   <= StIdle;
      col0_q    <= '0;
      col1_q    <= '0;
      row0_q    <= '0;
      row1_q    <= '0;
      pat_q     <= '0;
      clr_q     <= '0;
      cur_col_q <= '0;
      cur_row_q <= '0;
      rej_q     <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      color_q   <= '0;
      we_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      col0_q    <= col0_d;
      col1_q    <= col1_d;
      row0_q    <= row0_d;
      row1_q    <= row1_d;
      pat_q     <= pat_d;
      clr_q     <= clr_d;
      cur_col_q <= cur_col_d;
      cur_row_q <= cur_row_d;
      rej_q     <= rej_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      color_q   <= color_d;
      we_q      <= we_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign addr  = addr_q;
  assign data  = data_q;
  assign color = color_q;
  assign we    = we_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign err   = err_q;

endmodule

// File: tb/tb_vram_fill.sv
// Scoreboard bench for vram_fill: a rectangle model queues expected writes,
// a negedge monitor pops and compares them and checks done/err timing.
module tb_vram_fill;

  localparam int TbCols = 48;
  localparam int TbBase = 32'h9000;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
    logic [7:0]  c;
  } wr_t;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  col0 = '0, col1 = '0;
  logic [7:0]  row0 = '0, row1 = '0, pattern = '0, color_in = '0;
  logic        grant = 1'b1;
  logic [15:0] addr;
  logic [7:0]  data, color;
  logic        we, busy, done, err;

  vram_fill dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .start   (start),
    .col0    (col0),
    .col1    (col1),
    .row0    (row0),
    .row1    (row1),
    .pattern (pattern),
    .color_in(color_in),
    .grant   (grant),
    .addr    (addr),
    .data    (data),
    .color   (color),
    .we      (we),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  always #5 clk_sys = ~clk_sys;

  int n_chk = 0, n_fail = 0;
  wr_t exp_q[$];
  int  exp_n_q[$];
  int  exp_err_q[$];
  int  cyc = 0, start_cyc = 0, stalls = 0, gmode = 0;
  int  done_cnt = 0, we_cnt = 0;
  logic last_g = 1'b1;
  logic prev_done = 1'b0;
  logic [15:0] hold_a = '0;
  logic [7:0]  hold_d = '0, hold_c = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Cycle counter and count of refused write slots since the current start.
  initial forever @(posedge clk_sys) begin
    cyc++;
    last_g = grant;
    if (cyc >= start_cyc + 2 && grant == 1'b0) stalls++;
  end

  initial forever @(posedge clk_sys) begin
    #1;
    case (gmode)
      0: grant = 1'b1;
      1: grant = 1'($urandom_range(0, 1));
      default: grant = ~grant;
    endcase
  end

  initial forever @(negedge clk_sys) begin
    if (reset) begin
      hold_a = '0;
      hold_d = '0;
      hold_c = '0;
      prev_done = 1'b0;
    end else begin
      if (we) begin
        we_cnt++;
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_we: got addr %0h expected no write", addr);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("wr_addr", 32'(addr), 32'(e.a));
          chk("wr_data", 32'(data), 32'(e.d));
          chk("wr_color", 32'(color), 32'(e.c));
          hold_a = e.a;
          hold_d = e.d;
          hold_c = e.c;
        end
      end else begin
        chk("hold_addr", 32'(addr), 32'(hold_a));
        chk("hold_data_color", {16'd0, data, color}, {16'd0, hold_d, hold_c});
      end
      if (done) begin
        int sb;
        done_cnt++;
        chk("done_single_cycle", 32'(prev_done), 32'd0);
        if (exp_n_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_done: got done expected none");
        end else begin
          int en, ee;
          en = exp_n_q.pop_front();
          ee = exp_err_q.pop_front();
          sb = stalls - ((last_g == 1'b0) ? 1 : 0);
          chk("done_latency", 32'(cyc - start_cyc), 32'(2 + en + sb));
          chk("done_err", 32'(err), 32'(ee));
          chk("done_busy_low", 32'(busy), 32'd0);
        end
      end
      prev_done = done;
    end
  end

  task automatic issue(input int c0, input int c1, input int r0, input int r1,
                       input int p, input int cl);
    bit bad;
    int n = 0;
    bad = (c0 > c1) || (r0 > r1) || (c1 >= TbCols);
    if (!bad) begin
      for (int c = c0; c <= c1; c++) begin
        for (int r = r0; r <= r1; r++) begin
          wr_t w;
          w.a = 16'(TbBase + c * 256 + r);
          w.d = 8'(p);
          w.c = 8'(cl);
          exp_q.push_back(w);
          n++;
        end
      end
    end
    exp_n_q.push_back(n);
    exp_err_q.push_back(bad ? 1 : 0);
    @(posedge clk_sys);
    #1;
    col0 = 6'(c0);
    col1 = 6'(c1);
    row0 = 8'(r0);
    row1 = 8'(r1);
    pattern = 8'(p);
    color_in = 8'(cl);
    start = 1'b1;
    start_cyc = cyc + 1;
    stalls = 0;
    @(posedge clk_sys);
    #1;
    start = 1'b0;
    // Scramble the request inputs; only the latched copies may matter.
    col0 = 6'($urandom);
    col1 = 6'($urandom);
    row0 = 8'($urandom);
    row1 = 8'($urandom);
    pattern = 8'($urandom);
    color_in = 8'($urandom);
  endtask

  task automatic wait_done(input int budget);
    int n0 = done_cnt;
    int k = 0;
    while (done_cnt == n0 && k < budget) begin
      @(negedge clk_sys);
      #1;
      k++;
    end
    if (done_cnt == n0) begin
      n_chk++;
      n_fail++;
      $display("FAIL done_timeout: got no done expected done within %0d cycles", budget);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  initial begin
    int d0, w0;
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_data_color", {16'd0, data, color}, 32'd0);
    chk("rst_flags", {28'd0, we, busy, done, err}, 32'd0);
    @(posedge clk_sys);
    #1;
    reset = 1'b0;
    idle(2);

    // Small rectangle, continuous grant.
    issue(0, 1, 0, 2, 8'hAA, 8'h70);
    @(negedge clk_sys);
    chk("busy_after_start", 32'(busy), 32'd1);
    wait_done(50);
    chk("drain_small", 32'(exp_q.size()), 32'd0);
    chk("small_err", 32'(err), 32'd0);

    // Rejected requests.
    issue(5, 4, 0, 0, 1, 2);
    wait_done(10);
    idle(3);
    chk("err_held", 32'(err), 32'd1);
    issue(0, 48, 0, 0, 1, 2);
    wait_done(10);
    issue(0, 0, 9, 8, 1, 2);
    wait_done(10);

    // Alternating grant over a four-byte fill.
    gmode = 2;
    w0 = we_cnt;
    issue(3, 3, 10, 13, 8'h55, 8'h0F);
    wait_done(50);
    chk("toggle_we_count", 32'(we_cnt - w0), 32'd4);
    gmode = 0;

    // Row range touching 255.
    issue(47, 47, 250, 255, 8'h3C, 8'h12);
    wait_done(50);
    chk("drain_row255", 32'(exp_q.size()), 32'd0);

    // Second start while busy is ignored.
    w0 = we_cnt;
    issue(2, 2, 0, 7, 8'h81, 8'h44);
    idle(2);
    col0 = 6'd0; col1 = 6'd3; row0 = 8'd0; row1 = 8'd3;
    start = 1'b1;
    idle(1);
    start = 1'b0;
    wait_done(50);
    idle(5);
    chk("busy_start_we_count", 32'(we_cnt - w0), 32'd8);
    chk("busy_start_idle", 32'(busy), 32'd0);

    // Random rectangles with random grant.
    gmode = 1;
    for (int i = 0; i < 24; i++) begin
      int c0, c1, r0, r1, t;
      c0 = $urandom_range(0, 50);
      c1 = c0 + $urandom_range(0, 2);
      if (c1 > 63) c1 = 63;
      r0 = $urandom_range(0, 255);
      r1 = r0 + $urandom_range(0, 12);
      if (r1 > 255) r1 = 255;
      if ($urandom_range(0, 5) == 0) begin t = c0; c0 = c1; c1 = t; end
      if ($urandom_range(0, 5) == 0) begin t = r0; r0 = r1; r1 = t; end
      issue(c0, c1, r0, r1, $urandom_range(0, 255), $urandom_range(0, 255));
      wait_done(400);
      idle($urandom_range(0, 3));
    end
    chk("drain_random", 32'(exp_q.size()), 32'd0);
    gmode = 0;

    // Full screen.
    d0 = done_cnt;
    w0 = we_cnt;
    issue(0, 47, 0, 255, 8'hFF, 8'h07);
    wait_done(13000);
    idle(4);
    chk("full_we_count", 32'(we_cnt - w0), 32'd12288);
    chk("full_last_addr", 32'(addr), 32'hBFFF);
    chk("full_done_once", 32'(done_cnt - d0), 32'd1);

    // Reset in the middle of a large fill.
    d0 = done_cnt;
    w0 = we_cnt;
    issue(0, 20, 0, 255, 8'h99, 8'h66);
    begin
      int k = 0;
      while (we_cnt - w0 < 10 && k < 100) begin
        @(negedge clk_sys);
        #1;
        k++;
      end
    end
    chk("reset_prewrites", 32'((we_cnt - w0) >= 10), 32'd1);
    @(posedge clk_sys);
    #1;
    reset = 1'b1;
    @(posedge clk_sys);
    #1;
    exp_q.delete();
    exp_n_q.delete();
    exp_err_q.delete();
    @(negedge clk_sys);
    chk("abort_we_busy", {30'd0, we, busy}, 32'd0);
    chk("abort_outputs", {addr, data, color}, 32'd0);
    chk("abort_done_err", {30'd0, done, err}, 32'd0);
    @(posedge clk_sys);
    #1;
    reset = 1'b0;
    idle(20);
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
    chk("abort_idle", {30'd0, busy, we}, 32'd0);

    // Engine still usable after an abort.
    issue(1, 1, 4, 5, 8'h11, 8'h22);
    wait_done(20);
    chk("drain_after_abort", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
